uart_rx_core: RTL and testbench

- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first, idle-high line.
- Recovers each character from the rxd_i pin with 16x oversampling and presents it as a byte, a one-cycle ready strobe and a one-cycle framing-error strobe.
- Sits directly upstream of the command parser in the design. In simulation it feeds the testbench response checker, which samples the byte on the rising edge of the ready strobe.

---
 rtl/uart_rx_core.sv | 110 +++++++++++
 tb/tb_uart_rx_core.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Emits a byte with a one-cycle ready strobe, or a one-cycle framing-error strobe.
module uart_rx_core #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLOCK_RATE = 50000000
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       rxd_i,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       rx_busy
);
    localparam int OVERSAMPLE_DIV = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int DW = OVERSAMPLE_DIV > 1 ? $clog2(OVERSAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(OVERSAMPLE_DIV - 1);

    generate
        if (OVERSAMPLE_DIV < 1) begin : g_bad_div
            $error("uart_rx_core: CLOCK_RATE too low for 16x oversampling of BAUD_RATE");
        end
    endgenerate

    typedef enum logic [2:0] {WAIT_HI, IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rxd_m, rxd_s;
    logic [DW-1:0] div_cnt;
    logic          x16_tick;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd_i;
            rxd_s <= rxd_m;
        end
    end

    assign x16_tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) div_cnt <= '0;
        else div_cnt <= x16_tick ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) begin
            state       <= WAIT_HI;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
            case (state)
                WAIT_HI: if (rxd_s) state <= IDLE;
                IDLE: if (!rxd_s) begin
                    state   <= START;
                    os_cnt  <= '0;
                    rx_busy <= 1'b1;
                end
                START: if (x16_tick) begin
                    if (os_cnt != 4'd7) os_cnt <= os_cnt + 1'b1;
                    else if (!rxd_s) begin
                        state   <= DATA;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                DATA: if (x16_tick) begin
                    // os_cnt wraps 15 -> 0 on the sampling tick
                    os_cnt <= os_cnt + 1'b1;
                    if (os_cnt == 4'd15) begin
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: if (x16_tick) begin
                    os_cnt <= os_cnt + 1'b1;
                    if (os_cnt == 4'd15) begin
                        rx_busy <= 1'b0;
                        if (rxd_s) begin
                            state       <= IDLE;
                            rx_data     <= shift_reg;
                            rx_data_rdy <= 1'b1;
                        end else begin
                            state   <= WAIT_HI;
                            frm_err <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed checks of uart_rx_core at 1 Mbaud / 32 MHz (32 clocks per bit).
module tb_uart_rx_core;
    logic       clk_rx = 1'b0;
    logic       rst_clk_rx = 1'b0;
    logic       rxd_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_rdy, frm_err, rx_busy;

    int checks = 0, failures = 0;
    int rdy_cnt = 0, err_cnt = 0;
    logic both_seen = 1'b0, wide_seen = 1'b0, prev_rdy = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx_core #(.BAUD_RATE(1000000), .CLOCK_RATE(32000000)) dut (
        .clk_rx(clk_rx), .rst_clk_rx(rst_clk_rx), .rxd_i(rxd_i),
        .rx_data(rx_data), .rx_data_rdy(rx_data_rdy), .frm_err(frm_err), .rx_busy(rx_busy)
    );

    always #5 clk_rx = ~clk_rx;

    always @(negedge clk_rx) begin
        if (rx_data_rdy) begin
            rdy_cnt++;
            rx_q.push_back(rx_data);
        end
        if (frm_err) err_cnt++;
        if (rx_data_rdy && frm_err) both_seen = 1'b1;
        if (rx_data_rdy && prev_rdy) wide_seen = 1'b1;
        prev_rdy = rx_data_rdy;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bc;
        int         exp_rdy;
        logic [7:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rdy_cnt = 0;
        err_cnt = 0;
        both_seen = 1'b0;
        wide_seen = 1'b0;
        rx_q.delete();
    endtask

    task automatic hold(input logic v, input int n);
        rxd_i = v;
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(d[i], bc);
        hold(stop, bc);
    endtask

    task automatic check_clean(input string name);
        check({name, "_both"}, 32'(both_seen), 0);
        check({name, "_wide"}, 32'(wide_seen), 0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 32, 1, 8'h55, 0};
        vecs[1] = '{8'hC3, 1'b1, 31, 1, 8'hC3, 0};
        vecs[2] = '{8'hC3, 1'b1, 33, 1, 8'hC3, 0};
        vecs[3] = '{8'h5A, 1'b0, 32, 0, 8'hC3, 1};

        repeat (4) @(negedge clk_rx);
        check("rst_data", 32'(rx_data), 0);
        check("rst_rdy", 32'(rx_data_rdy), 0);
        check("rst_err", 32'(frm_err), 0);
        check("rst_busy", 32'(rx_busy), 0);
        rst_clk_rx = 1'b1;
        hold(1'b1, 40);

        for (int v = 0; v < 4; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].bc);
            hold(1'b1, 48);
            check($sformatf("vec%0d_rdy", v), 32'(rdy_cnt), 32'(vecs[v].exp_rdy));
            check($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_err", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), 32'(rx_busy), 0);
            check_clean($sformatf("vec%0d", v));
        end

        clear_mon();
        hold(1'b0, 6);
        hold(1'b1, 40);
        check("glitch_rdy", 32'(rdy_cnt), 0);
        check("glitch_err", 32'(err_cnt), 0);
        check("glitch_busy", 32'(rx_busy), 0);
        send_frame(8'h12, 1'b1, 32);
        hold(1'b1, 48);
        check("after_glitch_rdy", 32'(rdy_cnt), 1);
        check("after_glitch_data", 32'(rx_data), 32'h12);

        clear_mon();
        send_frame(8'hA5, 1'b1, 32);
        send_frame(8'h3C, 1'b1, 32);
        send_frame(8'h00, 1'b1, 32);
        send_frame(8'hFF, 1'b1, 32);
        hold(1'b1, 48);
        check("b2b_rdy", 32'(rdy_cnt), 4);
        check("b2b_err", 32'(err_cnt), 0);
        check("b2b_q0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'hA5);
        check("b2b_q1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'h3C);
        check("b2b_q2", 32'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 32'h00);
        check("b2b_q3", 32'(rx_q.size() > 3 ? rx_q[3] : 8'hxx), 32'hFF);
        check_clean("b2b");

        clear_mon();
        send_frame(8'h7E, 1'b0, 32);
        check("brk_err_at_stop", 32'(err_cnt), 1);
        hold(1'b0, 200);
        check("brk_err_hold", 32'(err_cnt), 1);
        check("brk_rdy", 32'(rdy_cnt), 0);
        check("brk_busy", 32'(rx_busy), 0);
        hold(1'b1, 48);
        check("brk_data", 32'(rx_data), 32'hFF);
        clear_mon();
        send_frame(8'h41, 1'b1, 32);
        hold(1'b1, 48);
        check("after_brk_rdy", 32'(rdy_cnt), 1);
        check("after_brk_data", 32'(rx_data), 32'h41);
        check("after_brk_err", 32'(err_cnt), 0);

        clear_mon();
        fork
            send_frame(8'h99, 1'b1, 32);
            begin
                repeat (32 * 5 + 10) @(posedge clk_rx);
                #3;
                check("mid_busy", 32'(rx_busy), 1);
                rst_clk_rx = 1'b0;
                #1;
                check("arst_data", 32'(rx_data), 0);
                check("arst_busy", 32'(rx_busy), 0);
                check("arst_rdy", 32'(rx_data_rdy), 0);
                check("arst_err", 32'(frm_err), 0);
            end
        join
        hold(1'b1, 10);
        rst_clk_rx = 1'b1;
        hold(1'b1, 48);
        check("arst_no_rdy", 32'(rdy_cnt), 0);
        check("arst_no_err", 32'(err_cnt), 0);
        send_frame(8'h66, 1'b1, 32);
        hold(1'b1, 48);
        check("after_rst_rdy", 32'(rdy_cnt), 1);
        check("after_rst_data", 32'(rx_data), 32'h66);
        check_clean("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
